shot_turn_controller: RTL and testbench

Turn and cue-shot sequencer for the pool game. Waits until all balls have been stopped (`balls_have_stoped` from the ball-stop detector) for a settle period, then arms the cue. It charges shot power while the strike key is held and fires a one-cycle velocity impulse for the cue ball on release. It then tracks the resulting motion back to rest and hands the turn to the next player.

---
 rtl/shot_turn_controller.sv | 169 ++++++++++++++++
 tb/tb_shot_turn_controller.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_turn_controller.sv
// Turn and cue-shot sequencer for the pool game.
// Settle, aim, charge, fire, then follow the motion back to rest.
module shot_turn_controller #(
    parameter int SETTLE_FRAMES  = 8,
    parameter int MAX_POWER      = 255,
    parameter int POWER_SHIFT    = 2,
    parameter int LAUNCH_TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               balls_have_stoped,
    input  logic               strike_key,
    input  logic signed [31:0] dir_x,
    input  logic signed [31:0] dir_y,
    input  logic               keep_turn,
    output logic               cue_ready,
    output logic [7:0]         power,
    output logic               shot_pulse,
    output logic signed [31:0] shot_vx,
    output logic signed [31:0] shot_vy,
    output logic               current_player
);

    typedef enum logic [2:0] {
        S_SETTLE,
        S_AIM,
        S_CHARGE,
        S_FIRE,
        S_LAUNCH_WAIT,
        S_MOVING
    } state_t;

    localparam logic [7:0]  MAXP    = 8'(MAX_POWER);
    localparam logic [31:0] SETTLEN = 32'(SETTLE_FRAMES);
    localparam logic [31:0] TIMEOUT = 32'(LAUNCH_TIMEOUT);

    state_t             state_q, state_d;
    logic [31:0]        settle_q, settle_d;
    logic [31:0]        launch_q, launch_d;
    logic [7:0]         power_q, power_d;
    logic               keep_q, keep_d;
    logic               player_q, player_d;
    logic               pulse_q, pulse_d;
    logic               cue_q, cue_d;
    logic signed [31:0] vx_q, vx_d;
    logic signed [31:0] vy_q, vy_d;

    logic signed [31:0] power_s;
    logic signed [31:0] prod_x, prod_y;
    logic               keep_hit;

    assign power_s  = {24'd0, power_q};
    assign prod_x   = dir_x * power_s;
    assign prod_y   = dir_y * power_s;
    assign keep_hit = keep_q | keep_turn;

    // Next-state logic; registered outputs follow the next state.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        launch_d = launch_q;
        power_d  = power_q;
        keep_d   = keep_q;
        player_d = player_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        unique case (state_q)
            S_SETTLE: begin
                power_d = 8'd0;
                if (!balls_have_stoped) begin
                    settle_d = 32'd0;
                end else if (startOfFrame) begin
                    if (settle_q + 32'd1 == SETTLEN) begin
                        settle_d = 32'd0;
                        state_d  = S_AIM;
                    end else begin
                        settle_d = settle_q + 32'd1;
                    end
                end
            end
            S_AIM: begin
                power_d = 8'd0;
                if (!balls_have_stoped) begin
                    state_d = S_SETTLE;
                end else if (strike_key && startOfFrame) begin
                    power_d = 8'd1;
                    state_d = S_CHARGE;
                end
            end
            S_CHARGE: begin
                if (!strike_key) begin
                    vx_d    = prod_x >>> POWER_SHIFT;
                    vy_d    = prod_y >>> POWER_SHIFT;
                    state_d = S_FIRE;
                end else if (startOfFrame && power_q < MAXP) begin
                    power_d = power_q + 8'd1;
                end
            end
            S_FIRE: begin
                power_d  = 8'd0;
                launch_d = 32'd0;
                state_d  = S_LAUNCH_WAIT;
            end
            S_LAUNCH_WAIT: begin
                if (!balls_have_stoped) begin
                    launch_d = 32'd0;
                    keep_d   = 1'b0;
                    state_d  = S_MOVING;
                end else if (startOfFrame) begin
                    if (launch_q + 32'd1 == TIMEOUT) begin
                        launch_d = 32'd0;
                        player_d = ~player_q;
                        state_d  = S_SETTLE;
                    end else begin
                        launch_d = launch_q + 32'd1;
                    end
                end
            end
            S_MOVING: begin
                if (balls_have_stoped) begin
                    if (!keep_hit) player_d = ~player_q;
                    keep_d  = 1'b0;
                    state_d = S_SETTLE;
                end else begin
                    keep_d = keep_hit;
                end
            end
            default: state_d = S_SETTLE;
        endcase
        pulse_d = (state_d == S_FIRE);
        cue_d   = (state_d == S_AIM);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= S_SETTLE;
            settle_q <= 32'd0;
            launch_q <= 32'd0;
            power_q  <= 8'd0;
            keep_q   <= 1'b0;
            player_q <= 1'b0;
            pulse_q  <= 1'b0;
            cue_q    <= 1'b0;
            vx_q     <= 32'sd0;
            vy_q     <= 32'sd0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            launch_q <= launch_d;
            power_q  <= power_d;
            keep_q   <= keep_d;
            player_q <= player_d;
            pulse_q  <= pulse_d;
            cue_q    <= cue_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
        end
    end

    assign cue_ready      = cue_q;
    assign power          = power_q;
    assign shot_pulse     = pulse_q;
    assign shot_vx        = vx_q;
    assign shot_vy        = vy_q;
    assign current_player = player_q;

endmodule

// File: tb/tb_shot_turn_controller.sv
// Directed bench for shot_turn_controller.
// Second instance uses POWER_SHIFT=0 to check the shift.
module tb_shot_turn_controller;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic sof = 1'b0;
    logic stopped = 1'b0;
    logic strike = 1'b0;
    logic keep = 1'b0;
    logic signed [31:0] dx = 0;
    logic signed [31:0] dy = 0;

    logic cue, pulse, player;
    logic [7:0] pwr;
    logic signed [31:0] vx, vy;
    logic cue0, pulse0, player0;
    logic [7:0] pwr0;
    logic signed [31:0] vx0, vy0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shot_turn_controller dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof),
        .balls_have_stoped(stopped), .strike_key(strike),
        .dir_x(dx), .dir_y(dy), .keep_turn(keep),
        .cue_ready(cue), .power(pwr), .shot_pulse(pulse),
        .shot_vx(vx), .shot_vy(vy), .current_player(player)
    );

    shot_turn_controller #(.POWER_SHIFT(0)) dut0 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof),
        .balls_have_stoped(stopped), .strike_key(strike),
        .dir_x(dx), .dir_y(dy), .keep_turn(keep),
        .cue_ready(cue0), .power(pwr0), .shot_pulse(pulse0),
        .shot_vx(vx0), .shot_vy(vy0), .current_player(player0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            sof = 1'b1;
            tick();
            sof = 1'b0;
            tick();
        end
    endtask

    task automatic arm();
        stopped = 1'b1;
        frames(8);
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (cue !== 1'b0 || pwr !== 8'd0 || pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctl: cue=%b pwr=%0d pulse=%b want 0 0 0",
                     cue, pwr, pulse);
        end
        n_cmp++;
        if (vx !== 0 || vy !== 0 || player !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_shot: vx=%0d vy=%0d pl=%b want 0 0 0",
                     vx, vy, player);
        end
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_settle();
        stopped = 1'b1;
        frames(7);
        n_cmp++;
        if (cue !== 1'b0) begin
            n_bad++;
            $display("FAIL settle7: cue=%b want 0", cue);
        end
        sof = 1'b1;
        tick();
        sof = 1'b0;
        n_cmp++;
        if (cue !== 1'b1) begin
            n_bad++;
            $display("FAIL settle8: cue=%b want 1", cue);
        end
        tick();
        stopped = 1'b0;
        tick();
        n_cmp++;
        if (cue !== 1'b0) begin
            n_bad++;
            $display("FAIL disturb: cue=%b want 0", cue);
        end
        stopped = 1'b1;
        frames(4);
        stopped = 1'b0;
        tick();
        stopped = 1'b1;
        frames(7);
        n_cmp++;
        if (cue !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch7: cue=%b want 0", cue);
        end
        frames(1);
        n_cmp++;
        if (cue !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch8: cue=%b want 1", cue);
        end
    endtask

    task automatic test_saturate_and_miss();
        dx = 0;
        dy = 0;
        strike = 1'b1;
        frames(1);
        n_cmp++;
        if (pwr !== 8'd1 || cue !== 1'b0) begin
            n_bad++;
            $display("FAIL charge1: pwr=%0d cue=%b want 1 0", pwr, cue);
        end
        frames(299);
        stopped = 1'b0;
        tick();
        stopped = 1'b1;
        n_cmp++;
        if (pwr !== 8'd255 || pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL saturate: pwr=%0d pulse=%b want 255 0",
                     pwr, pulse);
        end
        strike = 1'b0;
        tick();
        n_cmp++;
        if (pulse !== 1'b1 || vx !== 0) begin
            n_bad++;
            $display("FAIL fire0: pulse=%b vx=%0d want 1 0", pulse, vx);
        end
        tick();
        n_cmp++;
        if (pulse !== 1'b0 || pwr !== 8'd0) begin
            n_bad++;
            $display("FAIL after_fire: pulse=%b pwr=%0d want 0 0",
                     pulse, pwr);
        end
        frames(3);
        n_cmp++;
        if (player !== 1'b0) begin
            n_bad++;
            $display("FAIL miss3: player=%b want 0", player);
        end
        frames(1);
        n_cmp++;
        if (player !== 1'b1 || cue !== 1'b0) begin
            n_bad++;
            $display("FAIL miss4: pl=%b cue=%b want 1 0", player, cue);
        end
        frames(8);
        n_cmp++;
        if (cue !== 1'b1) begin
            n_bad++;
            $display("FAIL rearm: cue=%b want 1", cue);
        end
    endtask

    task automatic test_shot_keep();
        dx = 4;
        dy = -2;
        strike = 1'b1;
        frames(10);
        n_cmp++;
        if (pwr !== 8'd10) begin
            n_bad++;
            $display("FAIL power10: pwr=%0d want 10", pwr);
        end
        strike = 1'b0;
        tick();
        n_cmp++;
        if (pulse !== 1'b1 || vx !== 10 || vy !== -5) begin
            n_bad++;
            $display("FAIL shot_s2: p=%b vx=%0d vy=%0d want 1 10 -5",
                     pulse, vx, vy);
        end
        n_cmp++;
        if (pulse0 !== 1'b1 || vx0 !== 40 || vy0 !== -20) begin
            n_bad++;
            $display("FAIL shot_s0: p=%b vx=%0d vy=%0d want 1 40 -20",
                     pulse0, vx0, vy0);
        end
        tick();
        stopped = 1'b0;
        tick();
        n_cmp++;
        if (pulse !== 1'b0 || vx !== 10 || vy !== -5) begin
            n_bad++;
            $display("FAIL hold: p=%b vx=%0d vy=%0d want 0 10 -5",
                     pulse, vx, vy);
        end
        frames(19);
        keep = 1'b1;
        tick();
        keep = 1'b0;
        frames(30);
        stopped = 1'b1;
        tick();
        n_cmp++;
        if (player !== 1'b1 || cue !== 1'b0) begin
            n_bad++;
            $display("FAIL keep: pl=%b cue=%b want 1 0", player, cue);
        end
    endtask

    task automatic test_same_cycle();
        arm();
        strike = 1'b1;
        frames(3);
        sof = 1'b1;
        strike = 1'b0;
        tick();
        sof = 1'b0;
        n_cmp++;
        if (pulse !== 1'b1 || pwr !== 8'd3 || vx !== 3 || vy !== -2) begin
            n_bad++;
            $display("FAIL rel_sof: p=%b pw=%0d vx=%0d vy=%0d want 1 3 3 -2",
                     pulse, pwr, vx, vy);
        end
        n_cmp++;
        if (vx0 !== 12 || vy0 !== -6) begin
            n_bad++;
            $display("FAIL rel_s0: vx=%0d vy=%0d want 12 -6", vx0, vy0);
        end
        tick();
        stopped = 1'b0;
        tick();
        frames(5);
        stopped = 1'b1;
        keep = 1'b1;
        tick();
        keep = 1'b0;
        n_cmp++;
        if (player !== 1'b1) begin
            n_bad++;
            $display("FAIL keep_stop: player=%b want 1", player);
        end
        arm();
        strike = 1'b1;
        frames(1);
        strike = 1'b0;
        tick();
        tick();
        frames(3);
        sof = 1'b1;
        stopped = 1'b0;
        tick();
        sof = 1'b0;
        stopped = 1'b1;
        keep = 1'b1;
        tick();
        keep = 1'b0;
        n_cmp++;
        if (player !== 1'b1) begin
            n_bad++;
            $display("FAIL motion_wins: player=%b want 1", player);
        end
    endtask

    task automatic test_no_keep();
        arm();
        strike = 1'b1;
        frames(2);
        strike = 1'b0;
        tick();
        tick();
        stopped = 1'b0;
        tick();
        frames(5);
        stopped = 1'b1;
        tick();
        n_cmp++;
        if (player !== 1'b0) begin
            n_bad++;
            $display("FAIL no_keep: player=%b want 0", player);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        arm();
        strike = 1'b1;
        frames(1);
        strike = 1'b0;
        tick();
        tick();
        frames(4);
        n_cmp++;
        if (player !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset: player=%b want 1", player);
        end
        arm();
        strike = 1'b1;
        frames(37);
        n_cmp++;
        if (pwr !== 8'd37) begin
            n_bad++;
            $display("FAIL power37: pwr=%0d want 37", pwr);
        end
        resetN = 1'b0;
        #1;
        n_cmp++;
        if (pwr !== 8'd0 || player !== 1'b0 || pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: pw=%0d pl=%b p=%b want 0 0 0",
                     pwr, player, pulse);
        end
        strike = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (pulse !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL no_pulse: seen=%b want 0", seen);
        end
        frames(8);
        n_cmp++;
        if (cue !== 1'b1 || player !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset: cue=%b pl=%b want 1 0", cue, player);
        end
    endtask

    initial begin
        test_reset();
        test_settle();
        test_saturate_and_miss();
        test_shot_keep();
        test_same_cycle();
        test_no_keep();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
